// File: rtl/ibtb_update_queue.sv
// Training-record FIFO feeding the ibtb update port: merges back-to-back
// duplicates at the tail and issues at most one update per cycle from the head.
module ibtb_update_queue #(
  parameter int DEPTH  = 8,
  parameter int CW     = 16,
  parameter int GH_W   = 16,
  parameter int ASID_W = 8,
  parameter int INFO_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [37:0]                enq_src_pc38,
  input  logic [GH_W-1:0]            enq_ibtb_gh,
  input  logic [ASID_W-1:0]          enq_asid,
  input  logic [INFO_W-1:0]          enq_tgt_ibtb_info,
  input  logic                       update_stall,
  output logic                       update_valid,
  output logic [37:0]                update_src_pc38,
  output logic [GH_W-1:0]            update_ibtb_gh,
  output logic [ASID_W-1:0]          update_asid,
  output logic [INFO_W-1:0]          update_tgt_ibtb_info,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CW-1:0]              coalesce_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [37:0]       pc_mem   [DEPTH];
  logic [GH_W-1:0]   gh_mem   [DEPTH];
  logic [ASID_W-1:0] asid_mem [DEPTH];
  logic [INFO_W-1:0] info_mem [DEPTH];

  logic [AW-1:0] head, tail, tail_last;
  logic [OW-1:0] occ;
  logic [CW-1:0] coal;
  logic          empty, full, accept, deq, key_match, merge, push;

  assign empty     = (occ == '0);
  assign full      = (occ == OW'(DEPTH));
  assign enq_ready = ~full;
  assign accept    = enq_valid & enq_ready;

  // Head data comes straight from storage, so nothing on enq_* reaches update_*.
  assign update_valid         = ~empty & ~update_stall & ~RST;
  assign deq                  = update_valid;
  assign update_src_pc38      = pc_mem[head];
  assign update_ibtb_gh       = gh_mem[head];
  assign update_asid          = asid_mem[head];
  assign update_tgt_ibtb_info = info_mem[head];

  assign tail_last = tail - AW'(1);
  assign key_match = (pc_mem[tail_last] == enq_src_pc38) &&
                     (gh_mem[tail_last] == enq_ibtb_gh) &&
                     (asid_mem[tail_last] == enq_asid);
  // A lone entry leaving this cycle cannot absorb the new record; it is re-enqueued.
  assign merge = accept & ~empty & key_match & ~((occ == OW'(1)) & deq);
  assign push  = accept & ~merge;

  assign occupancy      = occ;
  assign coalesce_count = coal;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      coal <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        gh_mem[i]   <= '0;
        asid_mem[i] <= '0;
        info_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        pc_mem[tail]   <= enq_src_pc38;
        gh_mem[tail]   <= enq_ibtb_gh;
        asid_mem[tail] <= enq_asid;
        info_mem[tail] <= enq_tgt_ibtb_info;
        tail           <= tail + AW'(1);
      end
      if (merge) begin
        info_mem[tail_last] <= enq_tgt_ibtb_info;
        if (coal != '1) coal <= coal + CW'(1);
      end
      if (deq) head <= head + AW'(1);
      occ <= occ + OW'(push) - OW'(deq);
    end
  end

endmodule

// File: tb/tb_ibtb_update_queue.sv
// Directed bench for ibtb_update_queue: queue-level reference model checked every
// cycle, plus literal expectations on the observed update stream.
module tb_ibtb_update_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [37:0] enq_src_pc38 = '0;
  logic [15:0] enq_ibtb_gh = '0;
  logic [7:0]  enq_asid = '0;
  logic [31:0] enq_tgt_ibtb_info = '0;
  logic        update_stall = 1'b0;
  logic        update_valid;
  logic [37:0] update_src_pc38;
  logic [15:0] update_ibtb_gh;
  logic [7:0]  update_asid;
  logic [31:0] update_tgt_ibtb_info;
  logic [3:0]  occupancy;
  logic [15:0] coalesce_count;

  ibtb_update_queue #(.DEPTH(8), .CW(16), .GH_W(16), .ASID_W(8), .INFO_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_src_pc38(enq_src_pc38), .enq_ibtb_gh(enq_ibtb_gh),
    .enq_asid(enq_asid), .enq_tgt_ibtb_info(enq_tgt_ibtb_info),
    .update_stall(update_stall), .update_valid(update_valid),
    .update_src_pc38(update_src_pc38), .update_ibtb_gh(update_ibtb_gh),
    .update_asid(update_asid), .update_tgt_ibtb_info(update_tgt_ibtb_info),
    .occupancy(occupancy), .coalesce_count(coalesce_count)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [37:0] pc;
    logic [15:0] gh;
    logic [7:0]  asid;
    logic [31:0] info;
  } rec_t;

  rec_t        exp_q[$];      // model contents, head at index 0
  int          exp_coal = 0;
  logic [37:0] out_pc_q[$];   // update stream observed from the DUT
  logic [31:0] out_info_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference model: a queue of records, updated on every rising edge
  always @(posedge CLK) begin
    int   sz;
    bit   d, a, m;
    rec_t r, last;
    if (RST) begin
      exp_q.delete();
      exp_coal = 0;
    end else begin
      sz = exp_q.size();
      d  = (sz > 0) && !update_stall;
      a  = enq_valid && (sz < 8);
      r  = '{pc: enq_src_pc38, gh: enq_ibtb_gh, asid: enq_asid, info: enq_tgt_ibtb_info};
      m  = 0;
      if (a && sz > 0) begin
        last = exp_q[sz-1];
        m = (last.pc == r.pc) && (last.gh == r.gh) && (last.asid == r.asid) && !(sz == 1 && d);
      end
      if (m) begin
        last.info = r.info;
        exp_q[sz-1] = last;
        if (exp_coal != 65535) exp_coal++;
      end
      if (d) void'(exp_q.pop_front());
      if (a && !m) exp_q.push_back(r);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("update_valid", 64'(update_valid), 64'(exp_q.size() > 0 && !update_stall && !RST));
      check("enq_ready", 64'(enq_ready), 64'(exp_q.size() < 8));
      check("occupancy", 64'(occupancy), 64'(exp_q.size()));
      check("coalesce_count", 64'(coalesce_count), 64'(exp_coal));
      if (exp_q.size() > 0) begin
        check("head_pc", 64'(update_src_pc38), 64'(exp_q[0].pc));
        check("head_gh", 64'(update_ibtb_gh), 64'(exp_q[0].gh));
        check("head_asid", 64'(update_asid), 64'(exp_q[0].asid));
        check("head_info", 64'(update_tgt_ibtb_info), 64'(exp_q[0].info));
      end
    end
    if (update_valid === 1'b1) begin
      out_pc_q.push_back(update_src_pc38);
      out_info_q.push_back(update_tgt_ibtb_info);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [37:0] pc, input logic [15:0] gh,
                           input logic [7:0] asid, input logic [31:0] info);
    enq_valid = v;
    enq_src_pc38 = pc;
    enq_ibtb_gh = gh;
    enq_asid = asid;
    enq_tgt_ibtb_info = info;
  endtask

  task automatic do_reset();
    drive_enq(1'b0, '0, '0, '0, '0);
    update_stall = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    out_pc_q.delete();
    out_info_q.delete();
  endtask

  initial begin
    // reset
    do_reset();
    chk_en = 1;
    check("rst_valid", 64'(update_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ready", 64'(enq_ready), 64'd1);
    check("rst_coal", 64'(coalesce_count), 64'd0);
    check("rst_pc", 64'(update_src_pc38), 64'd0);

    // single pass, latency 1
    drive_enq(1'b1, 38'h100, 16'd3, 8'd1, 32'h11);
    tick();
    drive_enq(1'b0, '0, '0, '0, '0);
    check("single_valid", 64'(update_valid), 64'd1);
    check("single_pc", 64'(update_src_pc38), 64'h100);
    check("single_gh", 64'(update_ibtb_gh), 64'd3);
    check("single_asid", 64'(update_asid), 64'd1);
    tick();
    check("single_occ_after", 64'(occupancy), 64'd0);

    // fill under stall, ninth record rejected, drain in order
    do_reset();
    update_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_enq(1'b1, 38'h1000 + 38'(i), 16'(i), 8'd7, 32'(i));
      tick();
    end
    check("fill_occ", 64'(occupancy), 64'd8);
    check("fill_ready", 64'(enq_ready), 64'd0);
    drive_enq(1'b1, 38'h1fff, 16'd9, 8'd7, 32'd9);
    tick();
    drive_enq(1'b0, '0, '0, '0, '0);
    check("fill_occ_9th", 64'(occupancy), 64'd8);
    update_stall = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("fill_drain_count", 64'(out_pc_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < out_pc_q.size(); i++)
      check("fill_drain_pc", 64'(out_pc_q[i]), 64'h1000 + 64'(i));
    check("fill_occ_end", 64'(occupancy), 64'd0);

    // merge of back-to-back duplicates
    do_reset();
    update_stall = 1'b1;
    drive_enq(1'b1, 38'h200, 16'd5, 8'd2, 32'haaaa);
    tick();
    drive_enq(1'b1, 38'h200, 16'd5, 8'd2, 32'hbbbb);
    tick();
    drive_enq(1'b0, '0, '0, '0, '0);
    check("merge_occ", 64'(occupancy), 64'd1);
    check("merge_coal", 64'(coalesce_count), 64'd1);
    update_stall = 1'b0;
    tick();
    tick();
    check("merge_count", 64'(out_pc_q.size()), 64'd1);
    if (out_info_q.size() > 0) check("merge_info", 64'(out_info_q[0]), 64'hbbbb);

    // same key while the only entry is leaving: no merge
    do_reset();
    update_stall = 1'b1;
    drive_enq(1'b1, 38'h300, 16'd4, 8'd3, 32'h1);
    tick();
    update_stall = 1'b0;
    drive_enq(1'b1, 38'h300, 16'd4, 8'd3, 32'h2);
    tick();
    drive_enq(1'b0, '0, '0, '0, '0);
    check("nomerge_occ", 64'(occupancy), 64'd1);
    check("nomerge_coal", 64'(coalesce_count), 64'd0);
    tick();
    tick();
    check("nomerge_count", 64'(out_pc_q.size()), 64'd2);
    if (out_info_q.size() == 2) begin
      check("nomerge_info0", 64'(out_info_q[0]), 64'h1);
      check("nomerge_info1", 64'(out_info_q[1]), 64'h2);
    end

    // streaming across pointer wrap, then reset with a partly full queue
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_enq(1'b1, 38'h400 + 38'(i), 16'(i), 8'd5, 32'(i + 100));
      tick();
    end
    drive_enq(1'b0, '0, '0, '0, '0);
    tick();
    check("wrap_count", 64'(out_pc_q.size()), 64'd20);
    for (int i = 0; i < 20 && i < out_pc_q.size(); i++)
      check("wrap_pc", 64'(out_pc_q[i]), 64'h400 + 64'(i));
    update_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_enq(1'b1, 38'h500 + 38'(i), 16'd1, 8'd6, 32'(i));
      tick();
    end
    drive_enq(1'b0, '0, '0, '0, '0);
    check("prerst_occ", 64'(occupancy), 64'd5);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    update_stall = 1'b0;
    #1;
    check("midrst_occ", 64'(occupancy), 64'd0);
    check("midrst_valid", 64'(update_valid), 64'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
